// File: rtl/aes_key_scheduler_if.sv
// Key-load and round-key read bundle for the AES-128 key scheduler.
// The master drives requests; the slave (scheduler) drives status and read data.
interface aes_key_scheduler_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  logic         rd_valid;

  modport master (
    output start, key_in, rd_en, rd_addr,
    input  busy, done, keys_valid, rd_data, rd_valid
  );

  modport slave (
    input  start, key_in, rd_en, rd_addr,
    output busy, done, keys_valid, rd_data, rd_valid
  );
endinterface

// File: rtl/aes_key_scheduler.sv
// AES-128 key expansion: one round key per clock into an 11-entry key file.
// Only NUM_ROUNDS=10 is meaningful; the S-box is computed as GF(2^8) inverse plus affine map.
module aes_key_scheduler #(
  parameter int NUM_ROUNDS     = 10,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input logic               clk,
  input logic               rst,
  aes_key_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t       state_q, state_d;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic [127:0] w_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic         done_q;
  logic         rd_valid_q;
  logic [127:0] rd_data_q;
  logic         accept;
  logic         step;
  logic         rd_ok;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] next_rk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (0 maps to 0)
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // One FIPS-197 expansion step from the last written round key
  always_comb begin
    rot     = {w_q[23:0], w_q[31:24]};
    sub     = {sbox(rot[31:24]), sbox(rot[23:16]),
               sbox(rot[15:8]),  sbox(rot[7:0])};
    w0n     = w_q[127:96] ^ sub ^ {rcon_q, 24'h0};
    w1n     = w_q[95:64] ^ w0n;
    w2n     = w_q[63:32] ^ w1n;
    w3n     = w_q[31:0] ^ w2n;
    next_rk = {w0n, w1n, w2n, w3n};
  end

  // Next-state and control strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (round_q == LAST) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Round counter, rcon, working key and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      w_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        round_q <= 4'd1;
        rcon_q  <= 8'h01;
        w_q     <= bus.key_in;
      end else if (step) begin
        w_q    <= next_rk;
        rcon_q <= xtime(rcon_q);
        done_q <= (round_q == LAST);
        if (round_q != LAST) round_q <= round_q + 4'd1;
      end
    end
  end

  // Round-key file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else if (accept) begin
      rk[0] <= bus.key_in;
      if (CLEAR_ON_START) begin
        for (int i = 1; i <= NUM_ROUNDS; i++) rk[i] <= '0;
      end
    end else if (step) begin
      rk[round_q] <= next_rk;
    end
  end

  assign rd_ok = bus.rd_en && (state_q == READY) && (bus.rd_addr <= LAST);

  // Registered read port; a read racing a restart sees the old keys
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_ok) begin
      rd_data_q  <= rk[bus.rd_addr];
      rd_valid_q <= 1'b1;
    end else begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.busy       = (state_q == EXPAND);
  assign bus.keys_valid = (state_q == READY);
  assign bus.done       = done_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Scoreboard bench for aes_key_scheduler: FIPS-197 word-loop model,
// directed vectors plus random keys and random read traffic.
module tb_aes_key_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_key_scheduler_if bus();

  aes_key_scheduler #(
    .NUM_ROUNDS(10),
    .CLEAR_ON_START(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic         v;
    logic [127:0] d;
    int           tid;
    int           addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tid = 0;
  bit   ab;

  logic [127:0] mk [0:10];
  bit           mvalid = 1'b0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0] sbox_t [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic void model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc [0:9];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]],
             sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc[i / 4 - 1];
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      mk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Issue a read for the coming edge; expectation from the model
  task automatic rd(input logic [3:0] a);
    exp_t e;
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    e.due  = cyc + 1;
    e.v    = mvalid && (a <= 4'd10);
    e.d    = '0;
    if (e.v) e.d = mk[a];
    e.tid  = tid;
    e.addr = int'(a);
    sb.push_back(e);
  endtask

  // Issue a read whose answer is a published constant
  task automatic rd_const(input logic [3:0] a, input logic [127:0] val);
    exp_t e;
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    e.due  = cyc + 1;
    e.v    = 1'b1;
    e.d    = val;
    e.tid  = tid;
    e.addr = int'(a);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each registered read response with the queue head
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL rd t%0d a%0d: response missed", mon_e.tid, mon_e.addr);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      chk1($sformatf("rd_valid t%0d a%0d", mon_e.tid, mon_e.addr),
           bus.rd_valid, mon_e.v);
      chk($sformatf("rd_data t%0d a%0d", mon_e.tid, mon_e.addr),
          bus.rd_data, mon_e.d);
    end else if (!rst) begin
      chk1($sformatf("idle rd_valid c%0d", cyc), bus.rd_valid, 1'b0);
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk1({nm, " busy"}, bus.busy, 1'b0);
    chk1({nm, " done"}, bus.done, 1'b0);
    chk1({nm, " keys_valid"}, bus.keys_valid, 1'b0);
    chk1({nm, " rd_valid"}, bus.rd_valid, 1'b0);
    chk({nm, " rd_data"}, bus.rd_data, 128'h0);
  endtask

  // Start an expansion and follow it edge by edge
  task automatic do_start(input logic [127:0] key, input int poke,
                          input int rst_at, output bit aborted);
    int dones;
    dones   = 0;
    aborted = 1'b0;
    tid++;
    bus.start  = 1'b1;
    bus.key_in = key;
    tick();
    bus.start  = 1'b0;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    mvalid     = 1'b0;
    chk1($sformatf("t%0d busy@T", tid), bus.busy, 1'b1);
    chk1($sformatf("t%0d kv@T", tid), bus.keys_valid, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k == poke) begin
        bus.start  = 1'b1;
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (k == 3) rd(4'($urandom_range(0, 10)));
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs($sformatf("t%0d midrst", tid));
        aborted = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.rd_en = 1'b0;
        return;
      end
      tick();
      bus.start = 1'b0;
      if (bus.done) dones++;
      chk1($sformatf("t%0d done@T+%0d", tid, k), bus.done, k == 10);
      chk1($sformatf("t%0d busy@T+%0d", tid, k), bus.busy, k < 10);
      chk1($sformatf("t%0d kv@T+%0d", tid, k), bus.keys_valid, k == 10);
    end
    model_expand(key);
    mvalid = 1'b1;
    tick();
    if (bus.done) dones++;
    chk($sformatf("t%0d done pulses", tid), 128'(dones), 128'd1);
  endtask

  task automatic burst();
    for (int a = 0; a <= 10; a++) begin
      rd(4'(a));
      @(negedge clk);
    end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.key_in  = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Known-answer key
    do_start(KEY_A, 0, 0, ab);
    rd_const(4'd1, A1);
    tick();
    rd_const(4'd10, A10);
    tick();
    rd_const(4'd0, KEY_A);
    tick();

    // All-zero key
    do_start(128'h0, 0, 0, ab);
    rd_const(4'd1, Z1);
    tick();
    rd_const(4'd10, Z10);
    tick();

    // Out-of-range addresses, then back-to-back reads
    tid++;
    rd(4'd11);
    tick();
    rd(4'd15);
    tick();
    burst();
    tick();

    // Start during expansion is ignored
    do_start(KEY_A, 5, 0, ab);
    burst();
    rd_const(4'd10, A10);
    tick();

    // Restart in READY with a simultaneous read of old round 10
    rd_const(4'd10, A10);
    do_start(128'h0, 0, 0, ab);
    rd_const(4'd10, Z10);
    tick();

    // Random keys with random read traffic
    for (int n = 0; n < 4; n++) begin
      do_start({$urandom, $urandom, $urandom, $urandom}, 0, 0, ab);
      for (int c = 0; c < 24; c++) begin
        if ($urandom_range(0, 3) != 0) rd(4'($urandom_range(0, 15)));
        else bus.rd_en = 1'b0;
        @(negedge clk);
      end
      bus.rd_en = 1'b0;
      tick();
    end

    // Reset during expansion, then a fresh run
    do_start(KEY_A, 0, 6, ab);
    mvalid = 1'b0;
    chk1("post-rst kv", bus.keys_valid, 1'b0);
    rd(4'd1);
    tick();
    tick();
    do_start(KEY_A, 0, 0, ab);
    rd_const(4'd1, A1);
    tick();
    rd_const(4'd10, A10);
    tick();
    rd_const(4'd0, KEY_A);
    tick();

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, 0 required", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_scheduler.md
Name: aes_key_scheduler

Overview:
Sequences the AES-128 key expansion and serves the results to the cipher core. On a start request it computes all 11 round keys, one expansion step per clock, and stores them in an internal round-key file. Round keys are read by index through a registered read port. The block sits between the key-load interface and the round datapath, so the round datapath never waits on key expansion once the keys are valid.

Parameters:
NUM_ROUNDS, 10, number of expansion steps; only 10 (AES-128) is supported and any other value is illegal.
CLEAR_ON_START, 1, if 1, round-key file entries 1..10 are zeroed on the cycle start is accepted.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  single-cycle request to expand key_in.
key_in  input  128  cipher key in FIPS-197 byte order; key_in[127:120] is byte 0.
busy  output  1  high while expansion is in progress.
done  output  1  one-cycle pulse when round key 10 has been written.
keys_valid  output  1  high while all 11 stored round keys are valid.
rd_en  input  1  read request.
rd_addr  input  4  round-key index, 0..10.
rd_data  output  128  registered round key.
rd_valid  output  1  registered qualifier for rd_data.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, keys_valid=0, rd_data=0, rd_valid=0; round counter=0; rcon=8'h01; key file cleared to 0.
- States and transitions:
  - IDLE: waits for start.
  - EXPAND: performs the 10 expansion steps.
  - READY: keys are valid.
  - IDLE --start--> EXPAND.
  - EXPAND --round==10 written--> READY.
  - READY --start--> EXPAND.
- Start acceptance:
  - start is accepted in IDLE or READY. At accept edge T: rk[0] <= key_in, round <= 1, rcon <= 8'h01, keys_valid <= 0, busy <= 1.
  - If CLEAR_ON_START=1, rk[1..10] <= 0 at the same edge T.
- Expansion step: at edges T+1..T+10, rk[r] <= f(rk[r-1], rcon), using the FIPS-197 word recurrence:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - w0 = rk[127:96].
  - SubWord uses 4 internal combinational S-box lookups.
- rcon update: rcon <= xtime(rcon) after each step, giving the sequence 01,02,04,08,10,20,40,80,1b,36. Round counter increments to 10 and does not wrap.
- Completion at edge T+10: done=1 for exactly one cycle; keys_valid <= 1; busy <= 0; state=READY. Start-to-keys_valid latency is 10 cycles after the accept edge.
- start while in EXPAND is ignored; the current expansion continues unchanged and there is no queueing.
- start in READY restarts expansion. keys_valid falls at the accept edge, and prior keys are lost.
- Read port:
  - At an edge with rd_en=1, rd_data <= rk[rd_addr] and rd_valid <= 1, but only if keys_valid=1 and rd_addr<=10.
  - Otherwise (rd_en=0, rd_addr 11..15, or keys_valid=0): rd_data <= 0 and rd_valid <= 0.
  - Read latency is 1 cycle. Throughput is one read per cycle.
- Simultaneous start and rd_en in READY: the read uses the pre-start state (keys_valid=1 at that edge) and returns the old key. Expansion then restarts.
- Reset mid-EXPAND: immediate return to the reset state. A new start is required afterwards.
- key_in is sampled only at the accept edge; later changes have no effect.

Test Plan:
1. Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy for 10 cycles, done pulses once. rd_addr=1 returns a0fafe1788542cb123a339392a6c7605 with rd_valid. rd_addr=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6. rd_addr=0 returns the key.
2. key_in=0 -> rk[1]=62636363626363636263636362636363 and rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e. Check that done is asserted exactly 10 edges after the accept edge.
3. Read before keys_valid and read with rd_addr=11 or 15 -> rd_valid=0 and rd_data=0. Back-to-back reads of addresses 0..10 -> 11 consecutive valid outputs, each one cycle after its request.
4. start pulsed again at round 5 of EXPAND -> ignored. Final keys match the first key, and done pulses exactly once.
5. In READY, start with the zero key together with rd_en at rd_addr=10 -> the read returns the old round-10 key. keys_valid=0 until the new done. The new rk[10] equals b4ef5bcb3e92e21123e951cf6f8f188e.
6. Assert rst at round 6 -> outputs immediately reset and keys_valid=0. After a fresh start, test 1's vectors are reproduced.
